// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/subtract unit.
//   OP_ADD / OP_SUB : encoding of the 'sub' operand-mode bit.
//   cla_ngrp        : number of lookahead groups, which is also the number
//                     of pipeline stages.
//   cla_params_ok   : legality of a WIDTH/GROUP pair (GROUP divides WIDTH,
//                     WIDTH >= GROUP). The top level checks it at elaboration.
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int cla_ngrp(input int width, input int group);
    return width / group;
  endfunction

  function automatic bit cla_params_ok(input int width, input int group);
    return (group > 0) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result bus of cla_pipe_adder.
//   in_valid, a, b, cin, sub : operand beat (master -> unit)
//   in_ready                 : unit accepts a beat this cycle (unit -> master)
//   out_valid, sum, cout, ovf: result beat (unit -> master)
//   out_ready                : downstream takes the result (master -> unit)
//
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both 1. A source holding valid=1 keeps its payload unchanged until the
// transfer. in_ready is combinational from out_valid/out_ready; it never
// depends on in_valid. The result payload is held stable while
// out_valid=1 & out_ready=0.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead block, purely combinational.
//   a, b   : group operand bits (b already conditioned for subtract)
//   cin    : carry into bit 0 of the group
//   sum    : group sum bits
//   cout   : carry out of the group MSB
//   c_msb  : carry into the group MSB (used for signed overflow)
// Every internal carry is a flat sum of products of g, p and cin; no carry
// depends on another computed carry.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // c[i] = OR_j<i ( g[j] & p[j+1] & .. & p[i-1] ) | ( p[0] & .. & p[i-1] & cin )
  always_comb begin : lookahead
    logic term;
    logic acc;
    term = 1'b0;
    acc  = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= GROUP; i++) begin
      acc = 1'b0;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) begin
          term = term & p[m];
        end
        acc = acc | term;
      end
      term = cin;
      for (int m = 0; m < i; m++) begin
        term = term & p[m];
      end
      c[i] = acc | term;
    end
  end

  assign sum   = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined, parametrised carry-lookahead add/subtract unit.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : cla_pipe_adder_if slave (operands in, result out, valid/ready)
// Stage k resolves lookahead group k and registers: the sum bits produced so
// far, its group carry-out and the operand bits not yet consumed. The
// carry ripples one group per cycle, so a beat takes NGRP cycles and a new
// beat can enter every cycle. The whole pipe advances together when the
// output slot is free or being taken (no bubble collapsing).
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic              clk,
  input  logic              rst,
  cla_pipe_adder_if.slave   bus
);

  localparam int NGRP = cla_ngrp(WIDTH, GROUP);

  if (!cla_params_ok(WIDTH, GROUP)) begin : g_param_check
    $error("cla_pipe_adder: WIDTH (%0d) must be a positive multiple of GROUP (%0d)",
           WIDTH, GROUP);
  end

  logic adv;

  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    localparam int LO  = k * GROUP;      // sum bits already resolved on entry
    localparam int REM = WIDTH - LO;     // operand bits still to process

    logic [REM-1:0]      a_in;
    logic [REM-1:0]      b_in;
    logic                c_in;
    logic                v_in;
    logic [LO+GROUP-1:0] sum_nxt;
    logic [GROUP-1:0]    grp_sum;
    logic                grp_cout;
    logic                grp_cmsb;

    logic                v_r;
    logic [LO+GROUP-1:0] sum_r;
    logic                c_r;

    if (k == 0) begin : g_src
      // Subtract is A + ~B + 1; cin is ignored in that mode.
      assign a_in    = bus.a;
      assign b_in    = (bus.sub == OP_ADD) ? bus.b : ~bus.b;
      assign c_in    = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;
      assign v_in    = bus.in_valid;
      assign sum_nxt = grp_sum;
    end else begin : g_src
      assign a_in    = g_stage[k-1].g_fwd.a_r;
      assign b_in    = g_stage[k-1].g_fwd.b_r;
      assign c_in    = g_stage[k-1].c_r;
      assign v_in    = g_stage[k-1].v_r;
      assign sum_nxt = {grp_sum, g_stage[k-1].sum_r};
    end

    cla_group #(
      .GROUP (GROUP)
    ) u_grp (
      .a     (a_in[GROUP-1:0]),
      .b     (b_in[GROUP-1:0]),
      .cin   (c_in),
      .sum   (grp_sum),
      .cout  (grp_cout),
      .c_msb (grp_cmsb)
    );

    // Data only loads with a valid beat, so the final-stage outputs keep the
    // last result (or their reset value) while no beat is present.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r   <= 1'b0;
        sum_r <= '0;
        c_r   <= 1'b0;
      end else if (adv) begin
        v_r <= v_in;
        if (v_in) begin
          sum_r <= sum_nxt;
          c_r   <= grp_cout;
        end
      end
    end

    if (k < NGRP - 1) begin : g_fwd
      logic [REM-GROUP-1:0] a_r;
      logic [REM-GROUP-1:0] b_r;
      // Carry into the MSB only matters for the top group.
      logic                 cmsb_unused;

      assign cmsb_unused = grp_cmsb;

      always_ff @(posedge clk) begin
        if (adv && v_in) begin
          a_r <= a_in[REM-1:GROUP];
          b_r <= b_in[REM-1:GROUP];
        end
      end
    end else begin : g_last
      logic ovf_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (adv && v_in) begin
          ovf_r <= grp_cout ^ grp_cmsb;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NGRP-1].v_r;
  assign bus.sum       = g_stage[NGRP-1].sum_r;
  assign bus.cout      = g_stage[NGRP-1].c_r;
  assign bus.ovf       = g_stage[NGRP-1].g_last.ovf_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(16)) bus16 ();
  cla_pipe_adder_if #(.WIDTH(8))  bus8  ();
  cla_pipe_adder_if #(.WIDTH(32)) bus32 ();

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  cla_pipe_adder #(.WIDTH(8),  .GROUP(8)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  // Result layout: [65]=ovf, [64]=cout, [63:0]=sum (zero-extended).
  // ovf uses the sign rule: operands of equal sign giving a result of the
  // other sign.
  function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub, input int w);
    logic [63:0] mask, bb, full, s;
    logic co, ov, sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    bb   = sub ? (~b & mask) : (b & mask);
    full = (a & mask) + bb + (sub ? 64'd1 : {63'd0, cin});
    s    = full & mask;
    co   = full[w];
    sa   = a[w-1];
    sb   = bb[w-1];
    ss   = s[w-1];
    ov   = (sa == sb) && (ss != sa);
    return {ov, co, s};
  endfunction

  function automatic logic [65:0] obs16();
    return {bus16.ovf, bus16.cout, 48'd0, bus16.sum};
  endfunction

  function automatic logic [65:0] obs8();
    return {bus8.ovf, bus8.cout, 56'd0, bus8.sum};
  endfunction

  function automatic logic [65:0] obs32();
    return {bus32.ovf, bus32.cout, 32'd0, bus32.sum};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    bus16.in_valid = 0; bus16.a = '0; bus16.b = '0; bus16.cin = 0; bus16.sub = 0; bus16.out_ready = 1;
    bus8.in_valid  = 0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 0; bus8.sub  = 0; bus8.out_ready  = 1;
    bus32.in_valid = 0; bus32.a = '0; bus32.b = '0; bus32.cin = 0; bus32.sub = 0; bus32.out_ready = 1;
  endtask

  // Single beat on the 16-bit unit; lat = cycles from presentation to
  // out_valid, -1 on timeout.
  task automatic beat16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, output logic [65:0] res, output int lat);
    @(posedge clk); #1;
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub; bus16.in_valid = 1;
    @(posedge clk); #1;
    bus16.in_valid = 0;
    lat = 1;
    while (!bus16.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus16.out_valid) lat = -1;
    res = obs16();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_all();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    tests_run++;
    if ({bus16.out_valid, bus16.in_ready, bus16.cout, bus16.ovf, bus16.sum} !== {4'b0100, 16'h0}) begin
      tests_failed++;
      $display("FAIL reset16: got v=%b r=%b c=%b o=%b s=%h, want v=0 r=1 c=0 o=0 s=0000",
               bus16.out_valid, bus16.in_ready, bus16.cout, bus16.ovf, bus16.sum);
    end
    tests_run++;
    if ({bus8.out_valid, bus8.in_ready, bus8.cout, bus8.ovf, bus8.sum} !== {4'b0100, 8'h0}) begin
      tests_failed++;
      $display("FAIL reset8: got v=%b r=%b c=%b o=%b s=%h, want v=0 r=1 c=0 o=0 s=00",
               bus8.out_valid, bus8.in_ready, bus8.cout, bus8.ovf, bus8.sum);
    end
    tests_run++;
    if ({bus32.out_valid, bus32.in_ready, bus32.cout, bus32.ovf, bus32.sum} !== {4'b0100, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset32: got v=%b r=%b c=%b o=%b s=%h, want v=0 r=1 c=0 o=0 s=0",
               bus32.out_valid, bus32.in_ready, bus32.cout, bus32.ovf, bus32.sum);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta[7]   = '{16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000, 16'h00FF, 16'h0005};
    logic [15:0] tb_[7]  = '{16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'h0001, 16'h0000, 16'h0007};
    logic        tcin[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        tsub[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    // {ovf, cout, sum}
    logic [17:0] texp[7] = '{{2'b01, 16'h0000}, {2'b00, 16'hFFFE}, {2'b01, 16'h0002},
                             {2'b10, 16'h8000}, {2'b11, 16'h7FFF}, {2'b00, 16'h0100},
                             {2'b00, 16'hFFFE}};
    logic [65:0] res;
    logic [65:0] want;
    int lat;
    for (int i = 0; i < 7; i++) begin
      beat16(ta[i], tb_[i], tcin[i], tsub[i], res, lat);
      want = {texp[i][17:16], 48'd0, texp[i][15:0]};
      tests_run++;
      if (res !== want) begin
        tests_failed++;
        $display("FAIL directed%0d result: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                 i, res[65], res[64], res[15:0], want[65], want[64], want[15:0]);
      end
      tests_run++;
      if (lat !== 4) begin
        tests_failed++;
        $display("FAIL directed%0d latency: got %0d, want 4", i, lat);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    localparam int N = 20;
    logic [65:0] exp_q[$];
    logic [65:0] e;
    int sent = 0, got = 0, cyc = 0;
    logic have = 0;
    logic exp_rdy;
    while (got < N && cyc < 200) begin
      @(posedge clk); #1;
      bus16.out_ready = !(cyc >= 6 && cyc <= 9);
      if (!have && sent < N) begin
        bus16.a   = 16'($urandom_range(0, 65535));
        bus16.b   = 16'($urandom_range(0, 65535));
        bus16.cin = 1'($urandom_range(0, 1));
        bus16.sub = 1'($urandom_range(0, 1));
        have = 1;
      end
      bus16.in_valid = have;
      @(negedge clk);
      if (cyc < 24) begin
        exp_rdy = !(cyc >= 6 && cyc <= 9);
        tests_run++;
        if (bus16.in_ready !== exp_rdy) begin
          tests_failed++;
          $display("FAIL b2b in_ready cyc%0d: got %b, want %b", cyc, bus16.in_ready, exp_rdy);
        end
      end
      if (cyc >= 6 && cyc <= 9) begin
        tests_run++;
        if (bus16.out_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b stall_valid cyc%0d: got %b, want 1", cyc, bus16.out_valid);
        end
      end
      if (bus16.out_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b extra_output cyc%0d: got sum=%h, want no output", cyc, bus16.sum);
        end else if (obs16() !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL b2b result%0d cyc%0d: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                   got, cyc, bus16.ovf, bus16.cout, bus16.sum, exp_q[0][65], exp_q[0][64], exp_q[0][15:0]);
        end
        if (bus16.out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          got++;
        end
      end
      if (bus16.in_valid && bus16.in_ready) begin
        exp_q.push_back(ref_add({48'd0, bus16.a}, {48'd0, bus16.b}, bus16.cin, bus16.sub, 16));
        sent++;
        have = 0;
      end
      cyc++;
    end
    bus16.in_valid  = 0;
    bus16.out_ready = 1;
    tests_run++;
    if (got !== N) begin
      tests_failed++;
      $display("FAIL b2b count: got %0d results, want %0d", got, N);
    end
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (bus16.out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b drained: got out_valid=%b, want 0", bus16.out_valid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [65:0] res;
    int lat;
    @(posedge clk); #1;
    bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.cin = 0; bus16.sub = 0; bus16.in_valid = 1;
    @(posedge clk); #1;
    bus16.a = 16'h0F0F; bus16.b = 16'h0101;
    @(posedge clk); #1;
    bus16.a = 16'hAAAA; bus16.b = 16'h5555;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    bus16.in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus16.out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset cycle%0d: got out_valid=%b sum=%h, want out_valid=0", i, bus16.out_valid, bus16.sum);
      end
    end
    beat16(16'h1234, 16'h1111, 1'b0, 1'b0, res, lat);
    tests_run++;
    if (res !== {2'b00, 48'd0, 16'h2345}) begin
      tests_failed++;
      $display("FAIL midreset next_beat: got ovf=%b cout=%b sum=%h, want ovf=0 cout=0 sum=2345",
               res[65], res[64], res[15:0]);
    end
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL midreset latency: got %0d, want 4", lat);
    end
    @(posedge clk);
  endtask

  // Exhaustive a/b for the single-stage 8-bit unit; mode rotates through
  // add, add+cin and subtract.
  task automatic stream8();
    localparam int N = 65536;
    logic [65:0] exp_q[$];
    int acc_q[$];
    logic [65:0] e;
    int ac;
    int sent = 0, got = 0, cyc = 0;
    while (got < N && cyc < N + 100) begin
      @(posedge clk); #1;
      if (sent < N) begin
        bus8.a   = sent[15:8];
        bus8.b   = sent[7:0];
        bus8.sub = ((sent % 3) == 2);
        bus8.cin = ((sent % 3) == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        bus8.in_valid = 1;
      end else begin
        bus8.in_valid = 0;
      end
      @(negedge clk);
      if (bus8.out_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sweep8 extra_output: got sum=%h, want no output", bus8.sum);
        end else begin
          e  = exp_q.pop_front();
          ac = acc_q.pop_front();
          got++;
          if (obs8() !== e) begin
            tests_failed++;
            $display("FAIL sweep8 result: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                     bus8.ovf, bus8.cout, bus8.sum, e[65], e[64], e[7:0]);
          end
          tests_run++;
          if (cyc - ac !== 1) begin
            tests_failed++;
            $display("FAIL sweep8 latency: got %0d, want 1", cyc - ac);
          end
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        exp_q.push_back(ref_add({56'd0, bus8.a}, {56'd0, bus8.b}, bus8.cin, bus8.sub, 8));
        acc_q.push_back(cyc);
        sent++;
      end
      cyc++;
    end
    bus8.in_valid = 0;
    tests_run++;
    if (got !== N) begin
      tests_failed++;
      $display("FAIL sweep8 count: got %0d results, want %0d", got, N);
    end
  endtask

  // Random 32-bit beats; every 8th beat uses b=~a to exercise full
  // propagate chains across all eight groups.
  task automatic stream32();
    localparam int N = 10000;
    logic [65:0] exp_q[$];
    int acc_q[$];
    logic [65:0] e;
    int ac;
    int sent = 0, got = 0, cyc = 0;
    while (got < N && cyc < N + 100) begin
      @(posedge clk); #1;
      if (sent < N) begin
        bus32.a   = $urandom;
        bus32.b   = ((sent % 8) == 0) ? ~bus32.a : $urandom;
        bus32.cin = 1'($urandom_range(0, 1));
        bus32.sub = ($urandom_range(0, 3) == 0);
        bus32.in_valid = 1;
      end else begin
        bus32.in_valid = 0;
      end
      @(negedge clk);
      if (bus32.out_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sweep32 extra_output: got sum=%h, want no output", bus32.sum);
        end else begin
          e  = exp_q.pop_front();
          ac = acc_q.pop_front();
          got++;
          if (obs32() !== e) begin
            tests_failed++;
            $display("FAIL sweep32 result: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                     bus32.ovf, bus32.cout, bus32.sum, e[65], e[64], e[31:0]);
          end
          tests_run++;
          if (cyc - ac !== 8) begin
            tests_failed++;
            $display("FAIL sweep32 latency: got %0d, want 8", cyc - ac);
          end
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        exp_q.push_back(ref_add({32'd0, bus32.a}, {32'd0, bus32.b}, bus32.cin, bus32.sub, 32));
        acc_q.push_back(cyc);
        sent++;
      end
      cyc++;
    end
    bus32.in_valid = 0;
    tests_run++;
    if (got !== N) begin
      tests_failed++;
      $display("FAIL sweep32 count: got %0d results, want %0d", got, N);
    end
  endtask

  task automatic test_sweep();
    fork
      stream8();
      stream32();
    join
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    tests_failed++;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead add/subtract unit. It is the next generation of the 4-bit/16-bit lookahead adders: width and group size are generic, and it adds a registered pipeline, a subtract mode, an overflow flag and a valid/ready handshake with backpressure.
- Each pipeline stage resolves one lookahead group. The group carry ripples stage-to-stage, and operands and partial sums are skewed so that one result is delivered per cycle.
- It sits in datapaths as a drop-in, throughput-1 adder.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP and at least GROUP.
- GROUP, 4, bits per lookahead group, which is also bits resolved per pipeline stage.
- NGRP, WIDTH/GROUP, derived number of stages; not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, unit accepts a beat this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry in; ignored when sub=1.
- sub, input, 1, 0 = A+B+cin, 1 = A-B (A + ~B + 1).
- out_valid, output, 1, result beat valid.
- out_ready, input, 1, downstream accepts result.
- sum, output, WIDTH, result modulo 2^WIDTH.
- cout, output, 1, carry out of the MSB; for sub, 1 means no borrow.
- ovf, output, 1, signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valid bits are 0, so out_valid=0. sum=0, cout=0, ovf=0. Data registers in stages 1..NGRP-1 need not be reset but must not leak to the outputs while valid=0.
- Advance: adv = out_ready | ~out_valid. in_ready = adv, combinational. The whole pipeline shifts when adv=1 and holds every register when adv=0. Bubbles are not collapsed; the pipe is lock-step.
- Accept: a beat is accepted when in_valid & in_ready. Stage 0 valid is loaded with (in_valid & in_ready) whenever adv=1.
- Operand conditioning at entry: b_eff = sub ? ~b : b. c_eff = sub ? 1 : cin.
- Stage k (k = 0..NGRP-1) computes group k: p = a_k ^ b_k and g = a_k & b_k. Internal carries are produced by full lookahead equations; no intra-group ripple is allowed. The stage registers sum bits [k*GROUP +: GROUP], the group carry-out, the carry into that group's MSB (needed by the last stage for ovf), and the still-unprocessed upper operand bits.
- Stage k+1 consumes the registered group carry of stage k. Lower sum bits produced earlier travel with the beat.
- Latency: exactly NGRP cycles from acceptance to out_valid, assuming out_ready=1 throughout. Example: WIDTH=16, GROUP=4 gives 4 cycles.
- Throughput: 1 result per cycle while out_ready=1.
- The outputs sum/cout/ovf are the final-stage registers and are stable while out_valid=1 & out_ready=0. A beat leaves only on out_valid & out_ready.
- Simultaneous events:
  - Output is taken and new input is accepted in the same cycle: both happen.
  - in_valid=0 while adv=1: a bubble is inserted.
- Reset mid-operation: all in-flight beats are discarded, and out_valid=0 on the cycle after rst is sampled high. No partial result is emitted.
- Degenerate case WIDTH==GROUP: single stage, latency 1.
- Arithmetic is unsigned modulo 2^WIDTH. ovf is valid for both add and sub under two's-complement interpretation.

Decomposition:
- Shared package cla_pkg holds:
  - The parameter legality check: WIDTH % GROUP == 0, enforced by elaboration-time assertion.
  - The function computing NGRP.
  - The sub-mode encoding constants OP_ADD=0 and OP_SUB=1.
- Sub-module cla_group: purely combinational GROUP-bit lookahead. Inputs a, b, cin. Outputs sum, cout, c_msb. It is instantiated NGRP times via generate, one per stage.
- Top-level: per-stage skew registers, valid chain, and handshake.

Test Plan (WIDTH=16, GROUP=4, out_ready=1 unless stated):
- Carry across all groups: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0000, cout=1, ovf=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Also a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1, cout=1.
- Streaming with backpressure: 20 back-to-back random beats, with out_ready low for cycles 6-9. Required response:
  - in_ready low in exactly those cycles.
  - Outputs stable while stalled.
  - All 20 results in order, matching a reference model; none lost or duplicated.
- Reset mid-flight: issue 3 beats, assert rst for 1 cycle on the 2nd cycle -> out_valid=0 from the next cycle and none of the 3 results appear. The next beat issued after reset (0x1234+0x1111) yields 0x2345 after 4 cycles.
- Parameter sweep: WIDTH=8, GROUP=8 (latency 1) and WIDTH=32, GROUP=4 (latency 8). Exhaustive checks for 8-bit; 10k random checks for 32-bit, including cin=1 cases.
